// File: rtl/bcd_ex3_pkg.sv
// bcd_ex3_pkg: shared definitions for the serial BCD <-> Excess-3 encoder/decoder pair.
`default_nettype none

package bcd_ex3_pkg;

  // Bit position within the digit, plus the carry into that position.
  typedef enum logic [2:0] {
    B0    = 3'd0,
    B1_C0 = 3'd1,
    B1_C1 = 3'd2,
    B2_C0 = 3'd3,
    B2_C1 = 3'd4,
    B3_C0 = 3'd5,
    B3_C1 = 3'd6
  } bit_state_t;

  localparam logic [3:0] EX3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

`default_nettype wire

// File: rtl/bcd2ex3_bit_fsm.sv
// bcd2ex3_bit_fsm: carry-tracking serial adder of the constant 3, LSB-first.
`default_nettype none

module bcd2ex3_bit_fsm
  import bcd_ex3_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_first,
  output logic out_bit,
  output logic last_bit
);

  bit_state_t state;
  bit_state_t state_nxt;
  bit_state_t state_eff;

  // A flagged first bit restarts the digit regardless of where we were.
  assign state_eff = (in_valid && in_first) ? B0 : state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= B0;
    end else if (in_valid) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = B0;
    case (state_eff)
      B0:      state_nxt = in_bit ? B1_C1 : B1_C0;
      B1_C0:   state_nxt = in_bit ? B2_C1 : B2_C0;
      B1_C1:   state_nxt = B2_C1;
      B2_C0:   state_nxt = B3_C0;
      B2_C1:   state_nxt = in_bit ? B3_C1 : B3_C0;
      default: state_nxt = B0;
    endcase
  end

  always_comb begin
    out_bit  = 1'b0;
    last_bit = 1'b0;
    case (state_eff)
      B0:    out_bit = ~in_bit;
      B1_C0: out_bit = ~in_bit;
      B1_C1: out_bit =  in_bit;
      B2_C0: out_bit =  in_bit;
      B2_C1: out_bit = ~in_bit;
      B3_C0: begin
        out_bit  = in_bit;
        last_bit = in_valid;
      end
      B3_C1: begin
        out_bit  = ~in_bit;
        last_bit = in_valid;
      end
      default: out_bit = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bcd2ex3_serial.sv
// bcd2ex3_serial: bit-serial BCD to Excess-3 encoder with registered outputs.
// Optional input range check enabled by defining BCD2EX3_ERR_CHK_EN.
`default_nettype none

module bcd2ex3_serial
  import bcd_ex3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_first,
  output logic       out_valid,
  output logic       out_bit,
  output logic [3:0] ex3_digit,
  output logic       digit_done,
  output logic       digit_err,
  output logic       word_done
);

  localparam int            CW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  logic          fsm_bit;
  logic          last_bit;
  logic [2:0]    out_sr;
  logic [CW-1:0] digit_cnt;

  bcd2ex3_bit_fsm u_bit_fsm (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_first (in_first),
    .out_bit  (fsm_bit),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_sr     <= 3'b000;
      ex3_digit  <= 4'b0000;
      digit_done <= 1'b0;
      word_done  <= 1'b0;
      digit_cnt  <= '0;
    end else begin
      out_valid  <= in_valid;
      digit_done <= 1'b0;
      word_done  <= 1'b0;
      if (in_valid) begin
        out_bit <= fsm_bit;
        out_sr  <= {fsm_bit, out_sr[2:1]};
      end
      if (last_bit) begin
        ex3_digit  <= {fsm_bit, out_sr};
        digit_done <= 1'b1;
        word_done  <= (digit_cnt == LAST_IDX);
        digit_cnt  <= (digit_cnt == LAST_IDX) ? '0 : digit_cnt + 1'b1;
      end
    end
  end

`ifdef BCD2EX3_ERR_CHK_EN
  logic [2:0] in_sr;
  logic [3:0] bcd_digit;
  logic       err_r;

  // Three earlier bits plus the bit being accepted form the complete input digit.
  assign bcd_digit = {in_bit, in_sr};

  always_ff @(posedge clk) begin
    if (rst) begin
      in_sr <= 3'b000;
      err_r <= 1'b0;
    end else begin
      err_r <= 1'b0;
      if (in_valid) begin
        in_sr <= {in_bit, in_sr[2:1]};
      end
      if (last_bit) begin
        err_r <= (bcd_digit > BCD_MAX);
      end
    end
  end

  assign digit_err = err_r;
`else
  assign digit_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd2ex3_serial.sv
// tb_bcd2ex3_serial: randomized and directed checks against an arithmetic reference model.
`default_nettype none

module tb_bcd2ex3_serial;

  localparam int DIGITS = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       in_first;
  logic       out_valid;
  logic       out_bit;
  logic [3:0] ex3_digit;
  logic       digit_done;
  logic       digit_err;
  logic       word_done;

  bcd2ex3_serial #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_first   (in_first),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .ex3_digit  (ex3_digit),
    .digit_done (digit_done),
    .digit_err  (digit_err),
    .word_done  (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: digit value so far and bit position, plus word counter.
  int m_pos   = 0;
  int m_acc   = 0;
  int m_cnt   = 0;
  int m_ex3   = 0;
  int n_words = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_acc = 0;
    m_cnt = 0;
    m_ex3 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_first = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    model_reset();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_bit", int'(out_bit), 0);
    check("rst_ex3_digit", int'(ex3_digit), 0);
    check("rst_digit_done", int'(digit_done), 0);
    check("rst_digit_err", int'(digit_err), 0);
    check("rst_word_done", int'(word_done), 0);
  endtask

  // One clock: apply inputs, advance the model, compare the registered outputs.
  task automatic step(input logic v, input logic b, input logic f);
    int e_bit, e_done, e_err, e_word;
    in_valid = v; in_bit = b; in_first = f;
    e_bit = 0; e_done = 0; e_err = 0; e_word = 0;
    if (v) begin
      if (f) begin
        m_pos = 0;
        m_acc = 0;
      end
      m_acc = m_acc | (int'(b) << m_pos);
      e_bit = ((m_acc + 3) >> m_pos) & 1;
      if (m_pos == 3) begin
        e_done = 1;
        m_ex3  = (m_acc + 3) % 16;
`ifdef BCD2EX3_ERR_CHK_EN
        e_err  = (m_acc > 9) ? 1 : 0;
`endif
        e_word = (m_cnt == DIGITS - 1) ? 1 : 0;
        m_cnt  = (m_cnt + 1) % DIGITS;
        m_pos  = 0;
        m_acc  = 0;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0;
    check("out_valid", int'(out_valid), int'(v));
    if (v) check("out_bit", int'(out_bit), e_bit);
    check("digit_done", int'(digit_done), e_done);
    check("digit_err", int'(digit_err), e_err);
    check("word_done", int'(word_done), e_word);
    check("ex3_digit", int'(ex3_digit), m_ex3);
    if (e_word == 1) n_words++;
  endtask

  task automatic send_digit(input int d, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, d[i], (i == 0));
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 0);
        for (int k = 0; k < g; k++) step(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_first = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Digit 5: Excess-3 1000, then absolute expectations for 0, 9, 12.
    send_digit(5, 0);
    check("ex3_of_5", int'(ex3_digit), 8);
    send_digit(0, 0);
    check("ex3_of_0", int'(ex3_digit), 3);
    send_digit(9, 0);
    check("ex3_of_9", int'(ex3_digit), 12);
    send_digit(12, 0);
    check("ex3_of_12", int'(ex3_digit), 15);

    // Digit 7 with idle gaps between bits.
    for (int r = 0; r < 4; r++) send_digit(7, 3);
    check("ex3_of_7", int'(ex3_digit), 10);

    // Abort after two bits, then digit 2 with in_first.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    send_digit(2, 0);
    check("ex3_of_2", int'(ex3_digit), 5);

    // in_first colliding with the fourth bit suppresses the completion.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Reset mid-digit, then a clean digit.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    do_reset();
    send_digit(4, 0);
    check("ex3_of_4", int'(ex3_digit), 7);

    // Ten digits from a fresh reset: word_done after digits 4 and 8 only.
    do_reset();
    n_words = 0;
    for (int d = 0; d < 10; d++) send_digit(d, 1);
    check("word_count_10", n_words, 2);

    // Random stream with sporadic gaps and aborts.
    for (int i = 0; i < 600; i++) begin
      logic v, b, f;
      v = ($urandom_range(3, 0) != 0);
      b = $urandom_range(1, 0) == 1;
      f = v && ($urandom_range(9, 0) == 0);
      step(v, b, f);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
